// File: rtl/fp16_mul_normround_if.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mul_normround_if
// Brief    : Valid/ready bus between the significand multiplier register,
//            the FP16 normalize/round/pack stage and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface fp16_mul_normround_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] prod;
  logic [15:0] a_op;
  logic [15:0] b_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  modport master (
    output in_valid, prod, a_op, b_op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, prod, a_op, b_op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface
`default_nettype wire

// File: rtl/fp16_mul_normround.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mul_normround
// Brief    : FP16 multiply normalize / RNE round / pack, 2-stage pipeline
//            with full valid/ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module fp16_mul_normround (
  input  logic                  CLK,
  input  logic                  RST,
  fp16_mul_normround_if.slave   bus
);

  localparam logic [15:0] c_qnan    = 16'h7E00;
  localparam logic [14:0] c_inf_mag = 15'h7C00;
  localparam logic [7:0]  c_bias2   = 8'd35;
  localparam logic [7:0]  c_exp_max = 8'd31;
  localparam logic [7:0]  c_sh_lim  = 8'd12;

  // --------------------------------------------------------------------------
  // Operand decode
  // --------------------------------------------------------------------------
  logic        w_sign;
  logic [4:0]  w_ea;
  logic [4:0]  w_eb;
  logic [9:0]  w_fa;
  logic [9:0]  w_fb;
  logic [4:0]  w_ea_eff;
  logic [4:0]  w_eb_eff;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_a_zero;
  logic        w_b_zero;
  logic [21:0] w_p;

  assign w_sign   = bus.a_op[15] ^ bus.b_op[15];
  assign w_ea     = bus.a_op[14:10];
  assign w_eb     = bus.b_op[14:10];
  assign w_fa     = bus.a_op[9:0];
  assign w_fb     = bus.b_op[9:0];
  assign w_ea_eff = (w_ea == 5'd0) ? 5'd1 : w_ea;
  assign w_eb_eff = (w_eb == 5'd0) ? 5'd1 : w_eb;
  assign w_a_nan  = (w_ea == 5'h1F) && (w_fa != 10'd0);
  assign w_b_nan  = (w_eb == 5'h1F) && (w_fb != 10'd0);
  assign w_a_inf  = (w_ea == 5'h1F) && (w_fa == 10'd0);
  assign w_b_inf  = (w_eb == 5'h1F) && (w_fb == 10'd0);
  assign w_a_zero = (w_ea == 5'd0)  && (w_fa == 10'd0);
  assign w_b_zero = (w_eb == 5'd0)  && (w_fb == 10'd0);
  assign w_p      = bus.prod[21:0];

  // --------------------------------------------------------------------------
  // Special-operand classification
  // --------------------------------------------------------------------------
  logic        w_special;
  logic [15:0] w_spec_res;
  logic [3:0]  w_spec_flags;

  always_comb begin
    w_special    = 1'b1;
    w_spec_res   = c_qnan;
    w_spec_flags = 4'b0000;
    if (w_a_nan || w_b_nan) begin
      w_spec_res   = c_qnan;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_spec_res   = c_qnan;
      w_spec_flags = 4'b1000;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_res   = {w_sign, c_inf_mag};
    end else if (w_p == 22'd0) begin
      w_spec_res   = {w_sign, 15'd0};
    end else begin
      w_special    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-one search, exponent and normalize / denormalize shift
  // --------------------------------------------------------------------------
  logic [4:0]  w_lead;
  logic [21:0] w_norm;
  logic [7:0]  w_er;
  logic        w_er_tiny;
  logic        w_er_ovf;
  logic [7:0]  w_sh;
  logic [3:0]  w_shamt;
  logic [33:0] w_ext;
  logic [4:0]  w_expf;
  logic [9:0]  w_mant;
  logic        w_guard;
  logic        w_sticky;

  always_comb begin
    w_lead = 5'd0;
    for (int i = 0; i < 22; i++) begin
      if (w_p[i]) begin
        w_lead = 5'(i);
      end
    end
  end

  assign w_norm    = w_p << (5'd21 - w_lead);
  assign w_er      = {3'b000, w_ea_eff} + {3'b000, w_eb_eff} + {3'b000, w_lead} - c_bias2;
  assign w_er_tiny = w_er[7] || (w_er == 8'd0);
  assign w_er_ovf  = !w_er[7] && (w_er >= c_exp_max);
  assign w_sh      = 8'd1 - w_er;

  // A shift of 13 already pushes the whole significand below the guard bit,
  // so larger shifts are clamped there instead of being special-cased.
  assign w_shamt   = !w_er_tiny         ? 4'd0  :
                     (w_sh > c_sh_lim)  ? 4'd13 : w_sh[3:0];
  assign w_ext     = {w_norm, 12'd0} >> w_shamt;
  assign w_mant    = w_ext[32:23];
  assign w_guard   = w_ext[22];
  assign w_sticky  = |w_ext[21:0];
  assign w_expf    = w_er_tiny ? 5'd0 : w_er[4:0];

  // --------------------------------------------------------------------------
  // Pipeline control
  // --------------------------------------------------------------------------
  logic r1_valid;
  logic r2_valid;
  logic w_s1_adv;
  logic w_s2_adv;

  assign w_s2_adv     = !r2_valid || bus.out_ready;
  assign w_s1_adv     = w_s2_adv || !r1_valid;
  assign bus.in_ready = !r1_valid || w_s1_adv;

  // --------------------------------------------------------------------------
  // Stage 1 register
  // --------------------------------------------------------------------------
  logic        r1_special;
  logic [15:0] r1_spec_res;
  logic [3:0]  r1_spec_flags;
  logic        r1_sign;
  logic        r1_ovf;
  logic        r1_tiny;
  logic [4:0]  r1_expf;
  logic [9:0]  r1_mant;
  logic        r1_guard;
  logic        r1_sticky;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r1_valid      <= 1'b0;
      r1_special    <= 1'b0;
      r1_spec_res   <= 16'd0;
      r1_spec_flags <= 4'd0;
      r1_sign       <= 1'b0;
      r1_ovf        <= 1'b0;
      r1_tiny       <= 1'b0;
      r1_expf       <= 5'd0;
      r1_mant       <= 10'd0;
      r1_guard      <= 1'b0;
      r1_sticky     <= 1'b0;
    end else if (w_s1_adv) begin
      r1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r1_special    <= w_special;
        r1_spec_res   <= w_spec_res;
        r1_spec_flags <= w_spec_flags;
        r1_sign       <= w_sign;
        r1_ovf        <= w_er_ovf;
        r1_tiny       <= w_er_tiny;
        r1_expf       <= w_expf;
        r1_mant       <= w_mant;
        r1_guard      <= w_guard;
        r1_sticky     <= w_sticky;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: round-to-nearest-even, overflow, pack
  // --------------------------------------------------------------------------
  logic        w_inc;
  logic        w_inexact;
  logic [14:0] w_sum;
  logic [15:0] w_res;
  logic [3:0]  w_flags;

  assign w_inc     = r1_guard && (r1_sticky || r1_mant[0]);
  assign w_inexact = r1_guard || r1_sticky;
  // Carry out of the mantissa lands in the exponent field on purpose.
  assign w_sum     = {r1_expf, r1_mant} + {14'd0, w_inc};

  always_comb begin
    w_res   = {r1_sign, w_sum};
    w_flags = {2'b00, r1_tiny && w_inexact, w_inexact};
    if (r1_special) begin
      w_res   = r1_spec_res;
      w_flags = r1_spec_flags;
    end else if (r1_ovf || (w_sum[14:10] == 5'h1F)) begin
      w_res   = {r1_sign, c_inf_mag};
      w_flags = 4'b0101;
    end
  end

  logic [15:0] r2_result;
  logic [3:0]  r2_flags;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r2_valid  <= 1'b0;
      r2_result <= 16'd0;
      r2_flags  <= 4'd0;
    end else if (w_s2_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_res;
        r2_flags  <= w_flags;
      end
    end
  end

  assign bus.out_valid = r2_valid;
  assign bus.result    = r2_result;
  assign bus.flags     = r2_flags;

  logic w_unused;
  assign w_unused = &{1'b0, bus.prod[23:22], w_ext[33]};

endmodule
`default_nettype wire
